// File: rtl/load_store_unit.sv
// Load/store unit: turns one execute-stage request into a word-aligned memory access with byte enables.
// Aligns and extends load data. Holds the memory request until ack, and gives up after TIMEOUT cycles.
module load_store_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic                  is_store,
    input  logic [2:0]            funct3,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           store_data,
    output logic                  done,
    output logic [31:0]           load_data,
    output logic [1:0]            err,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_ack,
    input  logic [31:0]           mem_rdata
);
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] count;
    logic [2:0]    f3_q;
    logic [1:0]    lane_q;
    logic          st_q;

    logic          legal_f3, misalign, req_ok, timeout_hit;
    logic [3:0]    be_nxt;
    logic [31:0]   wdata_nxt, fmt;
    logic [7:0]    rbyte;
    logic [15:0]   rhalf;

    always_comb begin
        legal_f3 = is_store ? (funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b010)
                            : (funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b010 ||
                               funct3 == 3'b100 || funct3 == 3'b101);
        misalign = (funct3[1:0] == 2'b01 && addr[0]) ||
                   (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
        req_ok   = legal_f3 && !misalign;
    end

    // Stores replicate the datum into every lane so memory can pick it up from any byte position.
    always_comb begin
        be_nxt    = 4'b1111;
        wdata_nxt = store_data;
        if (is_store) begin
            case (funct3[1:0])
                2'b00: begin
                    be_nxt    = 4'(4'b0001 << addr[1:0]);
                    wdata_nxt = {4{store_data[7:0]}};
                end
                2'b01: begin
                    be_nxt    = 4'(4'b0011 << addr[1:0]);
                    wdata_nxt = {2{store_data[15:0]}};
                end
                default: begin
                    be_nxt    = 4'b1111;
                    wdata_nxt = store_data;
                end
            endcase
        end
    end

    always_comb begin
        rbyte = mem_rdata[{lane_q, 3'b000} +: 8];
        rhalf = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (f3_q)
            3'b000:  fmt = {{24{rbyte[7]}}, rbyte};
            3'b001:  fmt = {{16{rhalf[15]}}, rhalf};
            3'b010:  fmt = mem_rdata;
            3'b100:  fmt = {24'd0, rbyte};
            3'b101:  fmt = {16'd0, rhalf};
            default: fmt = 32'd0;
        endcase
    end

    assign timeout_hit = (count == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (lsu_valid) state_nxt = req_ok ? ACCESS : DONE;
            ACCESS:  if (mem_ack || timeout_hit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign lsu_ready = (state == IDLE) && !rst;
    assign mem_req   = (state == ACCESS);
    assign done      = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= '0;
            f3_q      <= 3'b000;
            lane_q    <= 2'b00;
            st_q      <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= 4'b0000;
            mem_wdata <= 32'd0;
            err       <= 2'b00;
            load_data <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    err       <= 2'b00;
                    load_data <= 32'd0;
                    if (lsu_valid) begin
                        f3_q   <= funct3;
                        lane_q <= addr[1:0];
                        st_q   <= is_store;
                        count  <= '0;
                        if (req_ok) begin
                            mem_we    <= is_store;
                            mem_addr  <= {addr[ADDR_WIDTH-1:2], 2'b00};
                            mem_be    <= be_nxt;
                            mem_wdata <= wdata_nxt;
                        end else begin
                            err <= 2'b01;
                        end
                    end
                end
                ACCESS: begin
                    count <= count + 1'b1;
                    // An ack on the final allowed cycle still wins over the timeout.
                    if (mem_ack || timeout_hit) begin
                        mem_we    <= 1'b0;
                        mem_addr  <= '0;
                        mem_be    <= 4'b0000;
                        mem_wdata <= 32'd0;
                        err       <= mem_ack ? 2'b00 : 2'b10;
                        load_data <= (mem_ack && !st_q) ? fmt : 32'd0;
                    end
                end
                default: begin
                    err       <= 2'b00;
                    load_data <= 32'd0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, timeout and reset corner cases, then random
// requests checked against an arithmetic model of the load/store rules.
module tb_load_store_unit;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        lsu_valid, lsu_ready, is_store, done, mem_req, mem_we, mem_ack;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data, load_data, mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  err;
    logic [3:0]  mem_be;

    int total = 0;
    int bad   = 0;

    load_store_unit #(.ADDR_WIDTH(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .lsu_valid(lsu_valid), .lsu_ready(lsu_ready),
        .is_store(is_store), .funct3(funct3), .addr(addr), .store_data(store_data),
        .done(done), .load_data(load_data), .err(err), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] rd;
        int          dly;
        logic [1:0]  e_err;
        logic [3:0]  e_be;
        logic [31:0] e_wd;
        logic [31:0] e_ld;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference rules: access size in bytes, natural alignment, lane replication and extension.
    task automatic model(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] rd,
                         output logic [1:0] e_err, output logic [3:0] e_be,
                         output logic [31:0] e_wd, output logic [31:0] e_ld);
        int     nbytes, off;
        bit     legal;
        longint val;
        nbytes = 1 << f3[1:0];
        off    = int'(a % 4);
        if (st) legal = (f3 == 0) || (f3 == 1) || (f3 == 2);
        else    legal = (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
        if (legal && (a % nbytes) != 0) legal = 0;
        e_err = legal ? 2'b00 : 2'b01;
        e_be  = st ? 4'(((1 << nbytes) - 1) << off) : 4'hF;
        e_wd  = 32'd0;
        for (int i = 0; i < 4; i++) e_wd[8*i +: 8] = d[8*(i % nbytes) +: 8];
        val = (longint'(rd) >> (8 * off)) & ((64'd1 << (8 * nbytes)) - 1);
        if (!f3[2] && nbytes < 4 && val >= (64'd1 << (8 * nbytes - 1)))
            val = val - (64'd1 << (8 * nbytes));
        e_ld = (st || !legal) ? 32'd0 : 32'(val);
    endtask

    // Entered and left at a negedge with the unit idle; dly<0 means memory never acks.
    task automatic txn(input string tag, input vec_t v);
        int    c, reqc, exp_lat, exp_reqc;
        bit    got, unstable;
        logic [31:0] a0, wd0;
        logic [3:0]  be0;
        logic        we0;
        chk({tag, "_ready"}, 32'(lsu_ready), 32'd1);
        lsu_valid  = 1'b1;
        is_store   = v.st;
        funct3     = v.f3;
        addr       = v.a;
        store_data = v.d;
        mem_ack    = 1'($urandom_range(0, 1));
        mem_rdata  = $urandom;
        @(negedge clk);
        lsu_valid  = 1'b0;
        is_store   = 1'($urandom_range(0, 1));
        funct3     = 3'($urandom);
        addr       = $urandom;
        store_data = $urandom;
        c = 1; reqc = 0; got = 0; unstable = 0;
        a0 = '0; wd0 = '0; be0 = '0; we0 = 1'b0;
        while (c < 200) begin
            if (done) begin
                got = 1;
                break;
            end
            if (mem_req) begin
                if (reqc == 0) begin
                    a0 = mem_addr; be0 = mem_be; wd0 = mem_wdata; we0 = mem_we;
                end else if (mem_addr !== a0 || mem_be !== be0 || mem_wdata !== wd0 || mem_we !== we0) begin
                    unstable = 1;
                end
                mem_ack   = (reqc == v.dly);
                mem_rdata = (reqc == v.dly) ? v.rd : $urandom;
                reqc++;
            end else begin
                mem_ack = 1'b0;
            end
            @(negedge clk);
            c++;
        end
        mem_ack = 1'b0;
        exp_lat  = (v.e_err == 2'b01) ? 1 : (v.e_err == 2'b10) ? TO + 1 : v.dly + 2;
        exp_reqc = (v.e_err == 2'b01) ? 0 : (v.e_err == 2'b10) ? TO : v.dly + 1;
        chk({tag, "_done_seen"}, 32'(got), 32'd1);
        chk({tag, "_latency"}, 32'(c), 32'(exp_lat));
        chk({tag, "_req_cycles"}, 32'(reqc), 32'(exp_reqc));
        chk({tag, "_err"}, 32'(err), 32'(v.e_err));
        chk({tag, "_load_data"}, load_data, v.e_ld);
        if (reqc > 0) begin
            chk({tag, "_mem_addr"}, a0, {v.a[31:2], 2'b00});
            chk({tag, "_mem_be"}, 32'(be0), 32'(v.e_be));
            chk({tag, "_mem_we"}, 32'(we0), 32'(v.st));
            if (v.st) chk({tag, "_mem_wdata"}, wd0, v.e_wd);
            chk({tag, "_mem_stable"}, 32'(unstable), 32'd0);
        end
        chk({tag, "_ready_in_done"}, 32'(lsu_ready), 32'd0);
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    vec_t vecs[12];

    initial begin
        vec_t v;
        bit   seen;

        vecs[0]  = '{1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0,        1, 2'b00, 4'b1111, 32'hDEADBEEF, 32'h0};
        vecs[1]  = '{1'b1, 3'b000, 32'h13, 32'h000000A5, 32'h0,        0, 2'b00, 4'b1000, 32'hA5A5A5A5, 32'h0};
        vecs[2]  = '{1'b1, 3'b001, 32'h12, 32'h00001234, 32'h0,        2, 2'b00, 4'b1100, 32'h12341234, 32'h0};
        vecs[3]  = '{1'b0, 3'b000, 32'h21, 32'h0,        32'h0000F000, 1, 2'b00, 4'b1111, 32'h0, 32'hFFFFFFF0};
        vecs[4]  = '{1'b0, 3'b100, 32'h21, 32'h0,        32'h0000F000, 0, 2'b00, 4'b1111, 32'h0, 32'h000000F0};
        vecs[5]  = '{1'b0, 3'b101, 32'h22, 32'h0,        32'h80010000, 3, 2'b00, 4'b1111, 32'h0, 32'h00008001};
        vecs[6]  = '{1'b0, 3'b010, 32'h06, 32'h0,        32'h0,        0, 2'b01, 4'b0000, 32'h0, 32'h0};
        vecs[7]  = '{1'b0, 3'b011, 32'h00, 32'h0,        32'h0,        0, 2'b01, 4'b0000, 32'h0, 32'h0};
        vecs[8]  = '{1'b1, 3'b001, 32'h11, 32'h0,        32'h0,        0, 2'b01, 4'b0000, 32'h0, 32'h0};
        vecs[9]  = '{1'b1, 3'b100, 32'h20, 32'h0,        32'h0,        0, 2'b01, 4'b0000, 32'h0, 32'h0};
        vecs[10] = '{1'b0, 3'b001, 32'h22, 32'h0,        32'h80010000, 1, 2'b00, 4'b1111, 32'h0, 32'hFFFF8001};
        vecs[11] = '{1'b0, 3'b010, 32'h24, 32'h0,        32'h12345678, 0, 2'b00, 4'b1111, 32'h0, 32'h12345678};

        rst = 1'b1; lsu_valid = 1'b0; is_store = 1'b0; funct3 = 3'b000;
        addr = 32'd0; store_data = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(lsu_ready), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_mem_be", 32'(mem_be), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_load_data", load_data, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 12; i++) txn($sformatf("vec%0d", i), vecs[i]);

        v = '{1'b0, 3'b010, 32'h40, 32'h0, 32'h0, -1, 2'b10, 4'b1111, 32'h0, 32'h0};
        txn("timeout", v);

        // Reset in the middle of an access: request drops, late ack must not produce done.
        lsu_valid = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h40;
        @(negedge clk);
        lsu_valid = 1'b0;
        chk("rstmid_req_up", 32'(mem_req), 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_req_drop", 32'(mem_req), 32'd0);
        chk("rstmid_ready_low", 32'(lsu_ready), 32'd0);
        rst = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'h55555555;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done || mem_req) seen = 1;
        end
        mem_ack = 1'b0;
        chk("rstmid_no_done", 32'(seen), 32'd0);
        v = '{1'b0, 3'b010, 32'h44, 32'h0, 32'hCAFEF00D, 2, 2'b00, 4'b1111, 32'h0, 32'hCAFEF00D};
        txn("after_rst", v);

        for (int i = 0; i < 40; i++) begin
            v.st  = 1'($urandom_range(0, 1));
            v.f3  = 3'($urandom);
            v.a   = $urandom;
            v.d   = $urandom;
            v.rd  = $urandom;
            v.dly = $urandom_range(0, 4);
            model(v.st, v.f3, v.a, v.d, v.rd, v.e_err, v.e_be, v.e_wd, v.e_ld);
            txn($sformatf("rnd%0d", i), v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
